// File: rtl/fft_pkg.sv
// fft_pkg
// Constants, sample type and index helper shared by the FFT frame streamer
// and the serial-to-frame reorder stage.
//   FFT_N      points per frame (32 only)
//   FFT_LOG2N  index width
//   FFT_W      signed width of each real/imaginary part
//   cplx_t     one signed complex sample
//   bitrev5()  5-bit bit-reversal of a lane index
package fft_pkg;

  localparam int FFT_N     = 32;
  localparam int FFT_LOG2N = 5;
  localparam int FFT_W     = 16;

  typedef struct packed {
    logic signed [FFT_W-1:0] re;
    logic signed [FFT_W-1:0] im;
  } cplx_t;

  // Mirror the five index bits so bit 0 becomes the MSB.
  function automatic logic [FFT_LOG2N-1:0] bitrev5(input logic [FFT_LOG2N-1:0] c);
    return {c[0], c[1], c[2], c[3], c[4]};
  endfunction

endpackage

// File: rtl/frame_bank.sv
// frame_bank
// One N-entry complex register file holding a full FFT frame.
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low clear of every entry
//   we       write all N lanes from wr_r/wr_i in one cycle
//   wr_r     packed real parts, lane k = bits [k*W +: W]
//   wr_i     packed imaginary parts, same packing
//   rd_addr  lane to read
//   rd_r     real part of lane rd_addr (combinational)
//   rd_i     imaginary part of lane rd_addr (combinational)
module frame_bank
  import fft_pkg::*;
#(
  parameter int N = FFT_N,
  parameter int W = FFT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [N*W-1:0]        wr_r,
  input  logic [N*W-1:0]        wr_i,
  input  logic [$clog2(N)-1:0]  rd_addr,
  output logic signed [W-1:0]   rd_r,
  output logic signed [W-1:0]   rd_i
);

  logic signed [W-1:0] mem_r [N];
  logic signed [W-1:0] mem_i [N];

  // Whole-frame parallel write; reset zeroes storage so the read port
  // presents 0 while the streamer is idle after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        mem_r[k] <= '0;
        mem_i[k] <= '0;
      end
    end else if (we) begin
      for (int k = 0; k < N; k++) begin
        mem_r[k] <= wr_r[k*W +: W];
        mem_i[k] <= wr_i[k*W +: W];
      end
    end
  end

  assign rd_r = mem_r[rd_addr];
  assign rd_i = mem_i[rd_addr];

endmodule

// File: rtl/fft_frame_streamer.sv
// fft_frame_streamer
// Accepts complete 32-point complex frames in parallel and streams them out
// one sample per beat with valid/ready flow control. Two ping-pong banks let
// a new frame load while the previous one drains.
// Parameters:
//   N       points per frame (32 only)
//   W       signed width of real/imaginary parts
//   BITREV  0 = natural output order, 1 = bit-reversed output order
// Ports:
//   clk, rst             clock; asynchronous active-low reset
//   load_valid/ready     frame load handshake
//   frame_r/frame_i      packed frame, lane k = bits [k*W +: W]
//   out_valid/ready      sample stream handshake
//   out_r/out_i          current sample
//   out_idx              frame lane index of the current sample
//   out_last             current beat is the frame's final sample
//   busy                 at least one bank holds a frame
module fft_frame_streamer
  import fft_pkg::*;
#(
  parameter int N      = FFT_N,
  parameter int W      = FFT_W,
  parameter int BITREV = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [N*W-1:0]        frame_r,
  input  logic [N*W-1:0]        frame_i,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [W-1:0]   out_r,
  output logic signed [W-1:0]   out_i,
  output logic [FFT_LOG2N-1:0]  out_idx,
  output logic                  out_last,
  output logic                  busy
);

  logic [1:0]           full;
  logic [1:0]           full_nxt;
  logic                 wr_bank;
  logic                 rd_bank;
  logic [FFT_LOG2N-1:0] c;
  logic [FFT_LOG2N-1:0] addr;
  logic                 load_fire;
  logic                 xfer;
  logic                 last_xfer;
  logic signed [W-1:0]  bank_r [2];
  logic signed [W-1:0]  bank_i [2];

  // Handshake terms depend only on registered flags and pointers, so
  // load_ready has no path from load_valid or out_ready.
  assign load_ready = !full[wr_bank];
  assign load_fire  = load_valid && load_ready;
  assign out_valid  = full[rd_bank];
  assign xfer       = out_valid && out_ready;
  assign last_xfer  = xfer && (c == 5'd31);
  assign busy       = full[0] | full[1];

  assign addr     = (BITREV != 0) ? bitrev5(c) : c;
  assign out_r    = bank_r[rd_bank];
  assign out_i    = bank_i[rd_bank];
  assign out_idx  = addr;
  assign out_last = (c == 5'd31) && out_valid;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    frame_bank #(.N(N), .W(W)) u_bank (
      .clk     (clk),
      .rst     (rst),
      .we      (load_fire && (wr_bank == 1'(b))),
      .wr_r    (frame_r),
      .wr_i    (frame_i),
      .rd_addr (addr),
      .rd_r    (bank_r[b]),
      .rd_i    (bank_i[b])
    );
  end

  // Per-bank flag update. A load and a final transfer in the same cycle
  // always touch different banks, because the load needs that bank empty.
  always_comb begin
    full_nxt = full;
    if (last_xfer) full_nxt[rd_bank] = 1'b0;
    if (load_fire) full_nxt[wr_bank] = 1'b1;
  end

  // Pointer and beat-counter state; the counter wraps naturally at 31 and
  // the read pointer advances to the other bank on the final beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      c       <= '0;
    end else begin
      full <= full_nxt;
      if (load_fire) wr_bank <= !wr_bank;
      if (xfer)      c       <= c + 5'd1;
      if (last_xfer) rd_bank <= !rd_bank;
    end
  end

endmodule
